// File: rtl/ac_pkg.sv
// Shared constants, FSM state type and frame-geometry helpers for the access-control AXIS master.
package ac_pkg;

    localparam int AC_AXIS_LANE_W = 32;
    localparam int AC_PAD_W       = 8;

    typedef enum logic {
        ST_IDLE,
        ST_STREAM
    } axis_state_e;

    function automatic int beats_per_row(input int img_w, input int n_par);
        return img_w / n_par;
    endfunction

    function automatic int rows_per_frame(input int img_h);
        return img_h;
    endfunction

endpackage

// File: rtl/ac_skid2.sv
// Two-entry fall-through FIFO: when empty, the incoming word is presented on the output in the
// same cycle, so a read can be chained straight through without a bubble.
module ac_skid2 #(
    parameter int W = 48
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   occupancy
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         wr_en;
    logic         rd_en;
    logic         push_store;
    logic         pop_store;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0) | in_valid;
    assign out_data  = (count != 2'd0) ? mem[rd_ptr] : in_data;
    assign occupancy = count;

    assign wr_en = in_valid & in_ready;
    assign rd_en = out_valid & out_ready;

    // A word that bypasses an empty FIFO is never stored.
    assign push_store = wr_en & ~((count == 2'd0) & rd_en);
    assign pop_store  = rd_en & (count != 2'd0);

    always_ff @(posedge clk) begin
        if (push_store) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_store) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop_store) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push_store} - {1'b0, pop_store};
        end
    end

endmodule

// File: rtl/ac_axis_master.sv
// AXI-Stream master after the access-control output buffer: pops pixel words, pads lanes to 32 bits,
// and marks frame start (tuser) / frame or row end (tlast). Define AC_AXIS_TLAST_ROW_EN for per-row tlast.
module ac_axis_master
    import ac_pkg::*;
#(
    parameter int UPSP_WRTDATA_WIDTH = 24,
    parameter int N_PARALLEL         = 2,
    parameter int DST_IMG_WIDTH      = 4096,
    parameter int DST_IMG_HEIGHT     = 2160
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [UPSP_WRTDATA_WIDTH*N_PARALLEL-1:0] buf_rdata,
    input  logic                                     buf_empty,
    output logic                                     buf_rd,
    output logic [AC_AXIS_LANE_W*N_PARALLEL-1:0]     m_axis_tdata,
    output logic [4*N_PARALLEL-1:0]                  m_axis_tkeep,
    output logic                                     m_axis_tvalid,
    input  logic                                     m_axis_tready,
    output logic                                     m_axis_tlast,
    output logic                                     m_axis_tuser,
    output logic                                     frame_done
);

    localparam int PIX_W  = UPSP_WRTDATA_WIDTH;
    localparam int WORD_W = PIX_W * N_PARALLEL;
    localparam int BEATS  = beats_per_row(DST_IMG_WIDTH, N_PARALLEL);
    localparam int ROWS   = rows_per_frame(DST_IMG_HEIGHT);
    localparam int COL_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

    axis_state_e state, state_nxt;

    logic              inflight;
    logic              skid_in_ready;
    logic              skid_out_valid;
    logic              skid_out_ready;
    logic [WORD_W-1:0] skid_out_data;
    logic [1:0]        skid_occ;
    logic              load;
    logic              accept;
    logic              last_col;
    logic              last_row;
    logic [COL_W-1:0]  col_cnt;
    logic [ROW_W-1:0]  row_cnt;
    logic [AC_AXIS_LANE_W*N_PARALLEL-1:0] padded;

    // Reserve a slot for every read before issuing it, counting the one still in flight.
    assign buf_rd = ~rst & ~buf_empty & skid_in_ready &
                    (({1'b0, skid_occ} + {2'b00, inflight}) < 3'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= buf_rd;
        end
    end

    ac_skid2 #(
        .W(WORD_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inflight),
        .in_ready  (skid_in_ready),
        .in_data   (buf_rdata),
        .out_valid (skid_out_valid),
        .out_ready (skid_out_ready),
        .out_data  (skid_out_data),
        .occupancy (skid_occ)
    );

    for (genvar j = 0; j < N_PARALLEL; j++) begin : g_lane
        assign padded[j*AC_AXIS_LANE_W +: AC_AXIS_LANE_W] =
            {{AC_PAD_W{1'b0}}, skid_out_data[j*PIX_W +: PIX_W]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        skid_out_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                skid_out_ready = 1'b1;
                if (skid_out_valid) begin
                    state_nxt = ST_STREAM;
                end
            end
            ST_STREAM: begin
                skid_out_ready = m_axis_tready;
                if (m_axis_tready && !skid_out_valid) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign load          = skid_out_valid & skid_out_ready;
    assign m_axis_tvalid = (state == ST_STREAM);
    assign accept        = m_axis_tvalid & m_axis_tready;
    assign m_axis_tkeep  = '1;

    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_tdata <= '0;
        end else if (load) begin
            m_axis_tdata <= padded;
        end
    end

    assign last_col = (col_cnt == COL_W'(BEATS - 1));
    assign last_row = (row_cnt == ROW_W'(ROWS - 1));

    // Counters hold the position of the beat currently on the bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt    <= '0;
            row_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= accept & last_col & last_row;
            if (accept) begin
                if (last_col) begin
                    col_cnt <= '0;
                    row_cnt <= last_row ? '0 : row_cnt + ROW_W'(1);
                end else begin
                    col_cnt <= col_cnt + COL_W'(1);
                end
            end
        end
    end

    assign m_axis_tuser = m_axis_tvalid & (col_cnt == '0) & (row_cnt == '0);

`ifdef AC_AXIS_TLAST_ROW_EN
    assign m_axis_tlast = m_axis_tvalid & last_col;
`else
    assign m_axis_tlast = m_axis_tvalid & last_col & last_row;
`endif

endmodule

// File: tb/tb_ac_axis_master.sv
// Randomized bench for ac_axis_master: a queue-based scoreboard predicts every beat, marker and frame pulse.
module tb_ac_axis_master;

    localparam int PW  = 24;
    localparam int NP  = 2;
    localparam int IW  = 16;
    localparam int IH  = 2;
    localparam int BPR = IW / NP;
    localparam int BPF = BPR * IH;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [47:0]   buf_rdata = '0;
    logic          buf_empty = 1'b1;
    logic          buf_rd;
    logic [63:0]   tdata;
    logic [7:0]    tkeep;
    logic          tvalid;
    logic          tready = 1'b0;
    logic          tlast;
    logic          tuser;
    logic          frame_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ac_axis_master #(
        .UPSP_WRTDATA_WIDTH (PW),
        .N_PARALLEL         (NP),
        .DST_IMG_WIDTH      (IW),
        .DST_IMG_HEIGHT     (IH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .buf_rdata     (buf_rdata),
        .buf_empty     (buf_empty),
        .buf_rd        (buf_rd),
        .m_axis_tdata  (tdata),
        .m_axis_tkeep  (tkeep),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tlast  (tlast),
        .m_axis_tuser  (tuser),
        .frame_done    (frame_done)
    );

    function automatic logic [47:0] mk_word(input int k);
        logic [23:0] p0, p1;
        p0 = 24'(2 * k);
        p1 = 24'(2 * k + 1);
        return {p1, p0};
    endfunction

    function automatic logic [63:0] pad(input logic [47:0] w);
        return {8'h00, w[47:24], 8'h00, w[23:0]};
    endfunction

    function automatic logic exp_last(input int idx);
`ifdef AC_AXIS_TLAST_ROW_EN
        return (idx % BPR) == BPR - 1;
`else
        return (idx % BPF) == BPF - 1;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Source buffer: word k carries pixels 2k and 2k+1, valid the cycle after the pop.
    int rd_cnt = 0;
    always @(posedge clk) begin
        if (buf_rd) begin
            buf_rdata <= mk_word(rd_cnt);
            rd_cnt    <= rd_cnt + 1;
        end
    end

    // Scoreboard: q holds every popped word not yet accepted, in pop order.
    logic [47:0] q[$];
    int          push_cnt  = 0;
    int          beat_idx  = 0;
    int          accepted  = 0;
    bit          fd_exp    = 1'b0;
    bit          hold_prev = 1'b0;
    logic [63:0] prev_data = '0;

    always @(negedge clk) begin
        chk("frame_done", frame_done, fd_exp);
        fd_exp = 1'b0;
        chk("tkeep", tkeep, 8'hFF);
        if (buf_rd) chk("rd_while_empty", buf_empty, 1'b0);
        chk("outstanding_le2", (int'(q.size()) - int'(tvalid)) <= 2, 1'b1);
        if (hold_prev) begin
            chk("hold_tvalid", tvalid, 1'b1);
            chk("hold_tdata", tdata, prev_data);
        end
        if (tvalid) begin
            chk("beat_has_data", q.size() != 0, 1'b1);
            if (q.size() != 0) begin
                chk("tdata", tdata, pad(q[0]));
                chk("tuser", tuser, (beat_idx % BPF) == 0);
                chk("tlast", tlast, exp_last(beat_idx));
            end
        end else begin
            chk("tuser_idle", tuser, 1'b0);
            chk("tlast_idle", tlast, 1'b0);
        end
        hold_prev = tvalid & ~tready & ~rst;
        prev_data = tdata;
        if (rst) begin
            q.delete();
            beat_idx = 0;
        end else begin
            if (tvalid && tready && q.size() != 0) begin
                void'(q.pop_front());
                if ((beat_idx % BPF) == BPF - 1) fd_exp = 1'b1;
                beat_idx++;
                accepted++;
            end
            if (buf_rd) q.push_back(mk_word(push_cnt));
        end
        if (buf_rd) push_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tvalid"}, tvalid, 1'b0);
        chk({tag, "_tdata"}, tdata, 64'h0);
        chk({tag, "_tlast"}, tlast, 1'b0);
        chk({tag, "_tuser"}, tuser, 1'b0);
        chk({tag, "_frame_done"}, frame_done, 1'b0);
    endtask

    initial begin
        int a;
        int guard;

        // Reset with a non-empty buffer: no pop may be issued while in reset.
        rst       = 1'b1;
        buf_empty = 1'b0;
        tready    = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk_reset_outputs("por");
        chk("por_buf_rd", buf_rd, 1'b0);

        // Continuous stream: pop at c0, first beat on the bus at c2.
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("lat_c0_buf_rd", buf_rd, 1'b1);
        chk("lat_c0_tvalid", tvalid, 1'b0);
        @(negedge clk);
        chk("lat_c1_tvalid", tvalid, 1'b0);
        @(negedge clk);
        chk("lat_c2_tvalid", tvalid, 1'b1);
        chk("lat_c2_lane0", tdata[31:0], 32'h0000_0000);
        chk("lat_c2_lane1", tdata[63:32], 32'h0000_0001);
        chk("lat_c2_tuser", tuser, 1'b1);
        repeat (4) step();
        a = accepted;
        repeat (16) step();
        chk("throughput_16", accepted - a, 16);
        repeat (20) step();

        // Backpressure mid-row: pops stop once two words are held.
        guard = 0;
        while ((beat_idx % BPR) != 3 && guard < 100) begin step(); guard++; end
        chk("wait_mid_row", guard < 100, 1'b1);
        tready = 1'b0;
        repeat (5) step();
        @(negedge clk);
        chk("bp_buf_rd_stall", buf_rd, 1'b0);
        chk("bp_tvalid_held", tvalid, 1'b1);
        step();
        tready = 1'b1;
        repeat (20) step();

        // Bursty source.
        for (int i = 0; i < 60; i++) begin
            buf_empty = i[0];
            tready    = ($urandom_range(0, 3) != 0);
            step();
        end

        // Fully random source and sink.
        for (int i = 0; i < 300; i++) begin
            buf_empty = ($urandom_range(0, 3) == 0);
            tready    = ($urandom_range(0, 3) != 0);
            step();
        end

        // Reset mid-frame at beat 5 with the skid full.
        buf_empty = 1'b0;
        tready    = 1'b1;
        guard = 0;
        while ((beat_idx % BPF) != 5 && guard < 100) begin step(); guard++; end
        chk("wait_beat5", guard < 100, 1'b1);
        tready = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_buf_rd", buf_rd, 1'b0);
        step();
        rst    = 1'b0;
        tready = 1'b1;
        @(negedge clk);
        chk_reset_outputs("mid_rst");
        guard = 0;
        while (!tvalid && guard < 20) begin @(negedge clk); guard++; end
        chk("post_rst_valid", tvalid, 1'b1);
        chk("post_rst_tuser", tuser, 1'b1);
        repeat (40) step();

        // Drain.
        buf_empty = 1'b1;
        guard = 0;
        while (q.size() != 0 && guard < 50) begin step(); guard++; end
        chk("drain", q.size(), 0);
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end

endmodule

// File: doc/ac_axis_master.md
# ac_axis_master

AXI-Stream master stage directly downstream of the access-control output buffer. It pops N_PARALLEL-pixel words from the buffer's read port and holds them in a 2-entry skid buffer. It pads each 24-bit pixel to a 32-bit lane and drives the IP-to-PS AXI-Stream bus with frame-start (tuser) and row/frame-end (tlast) markers, tracking position with column and row counters.

## Interface
Parameters:
- UPSP_WRTDATA_WIDTH, 24, bits per pixel from the buffer
- N_PARALLEL, 2, pixels per buffer word / per AXIS beat
- DST_IMG_WIDTH, 4096, pixels per row; multiple of 4*N_PARALLEL
- DST_IMG_HEIGHT, 2160, rows per frame

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- buf_rdata  in  UPSP_WRTDATA_WIDTH*N_PARALLEL  buffer read data; valid the cycle after buf_rd
- buf_empty  in  1  buffer has no word
- buf_rd  out  1  pop request to buffer
- m_axis_tdata  out  32*N_PARALLEL  lane j = {8'h00, pixel j}
- m_axis_tkeep  out  4*N_PARALLEL  constant all-ones
- m_axis_tvalid  out  1  beat valid
- m_axis_tready  in  1  sink ready
- m_axis_tlast  out  1  row/frame end (see Configuration)
- m_axis_tuser  out  1  first beat of frame
- frame_done  out  1  one-cycle pulse after the last beat of a frame is accepted

## Operation
- Lane mapping: buf_rdata[j*UPSP_WRTDATA_WIDTH +: 24] → m_axis_tdata[j*32 +: 32], upper 8 bits zero.
- Skid buffer: 2 entries, plus an in-flight flag covering one pending read. buf_rd = ~buf_empty & (occupancy + inflight < 2). inflight is set on buf_rd and cleared the next cycle, when the captured buf_rdata is written into the skid buffer.
- Output register: loaded from the skid head when empty or when the current beat is accepted.
- Counters: col_cnt counts 0..DST_IMG_WIDTH/N_PARALLEL-1 and row_cnt counts 0..DST_IMG_HEIGHT-1. Both advance only on accepted beats (tvalid & tready). col_cnt wraps to 0 and increments row_cnt. row_cnt wraps to 0 at frame end.
- tuser = (row_cnt==0 & col_cnt==0) for the beat currently on the bus.
- Frame end (last col, last row accepted): frame_done pulses, both counters wrap to 0, and streaming continues seamlessly into the next frame. No idle state is needed.
- States: IDLE (no beat on bus) → STREAM (tvalid=1). STREAM → IDLE when the beat is accepted and no skid entry is ready.

## Timing
- Reset values: buf_rd=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tuser=0, frame_done=0, counters=0, skid empty, inflight=0.
- Latency: buf_rd at cycle t → data captured at t+1 → tvalid at t+2 when the output is empty.
- Sustained throughput is one beat/cycle while ~buf_empty and tready=1.
- Stability: while tvalid & ~tready, tdata, tlast, tuser and tvalid are held; no beat is dropped or duplicated.
- Backpressure: the skid plus inflight never exceeds 2. A read is never issued without a free slot.
- Simultaneous skid write and output load in one cycle: occupancy is unchanged and order is preserved (FIFO).
- buf_empty rising with a read in flight: the in-flight data is still captured.
- rst mid-frame: all state clears next edge and any data in the skid is discarded. The next beat carries tuser=1.

## Configuration
- AC_AXIS_TLAST_ROW_EN defined: tlast=1 on col_cnt==DST_IMG_WIDTH/N_PARALLEL-1 (every row end).
- Undefined: tlast=1 only on the last beat of the frame (last col & last row).
- tuser and frame_done are identical in both builds.

## Structure
- Shared package ac_pkg holds AC_AXIS_LANE_W=32, the pad width (8), and the beats-per-row and rows-per-frame constant functions.
- One sub-module, ac_skid2: a 2-entry skid FIFO with in/out valid-ready and an occupancy output. The top holds counters, marker logic and read control.

## Test plan
Bench parameters: DST_IMG_WIDTH=16, DST_IMG_HEIGHT=2, N_PARALLEL=2 (8 beats/row, 16 beats/frame).
- Continuous stream: buffer always non-empty with incrementing pixels, tready=1 → one beat per cycle after 2-cycle fill. Lane 0 of beat 0 = 32'h00_000000 and tuser=1 only on beat 0. tlast on beats 7 and 15 with AC_AXIS_TLAST_ROW_EN, only on beat 15 without.
- Backpressure: tready low for 5 cycles mid-row → tdata/tlast held, buf_rd deasserts once skid+inflight=2, no loss/duplication across 16 beats.
- Bursty source: buf_empty toggles every other cycle → tvalid gaps, order preserved, col/row counts unchanged by gaps.
- Frame wrap: 2 frames back-to-back → frame_done pulses once at cycle after beat 15 accepted, beat 16 has tuser=1.
- Reset mid-frame: rst at beat 5 with 2 entries in skid → outputs at reset values next cycle, following beat has tuser=1 and starts at col 0.
